// File: rtl/nubus_slave_ctrl.sv
// NuBus slave cycle engine: decodes start cycles aimed at this slot, issues a
// single-beat local request and drives the ack/status response through the CPLD.
module nubus_slave_ctrl #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [1:0]  ST_OK_N  = 2'b00,
    parameter logic [1:0]  ST_ERR_N = 2'b01
) (
    input  logic        sys_clk,
    input  logic        sys_rst,

    input  logic        nubus_clk_n,
    input  logic [3:0]  id_n,
    input  logic        start_n_i,
    input  logic        ack_n_i,
    input  logic        tm0_n_i,
    input  logic        tm1_n_i,
    input  logic [31:0] ad_n_i,

    output logic        ack_n_o,
    output logic        tm0_n_o,
    output logic        tm1_n_o,
    output logic [31:0] ad_n_o,
    output logic        ad_oe,
    output logic        nubus_oe,
    output logic        nubus_master_dir,
    output logic        tmoen,

    output logic        req_valid,
    input  logic        req_ready,
    output logic        req_we,
    output logic [21:0] req_addr,
    output logic [3:0]  req_be,
    output logic [31:0] req_wdata,

    input  logic        resp_valid,
    input  logic [31:0] resp_rdata,

    output logic        busy,
    output logic        drop,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WDATA   = 3'd1,
        S_REQ     = 3'd2,
        S_WAIT    = 3'd3,
        S_ASETUP  = 3'd4,
        S_ACK     = 3'd5,
        S_RELEASE = 3'd6
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

    state_t      state;
    logic [2:0]  clk_sync;
    logic        sample;
    logic        drive;
    logic [31:0] addr_a;
    logic        start_hit;
    logic [3:0]  be_calc;
    logic [7:0]  tmo_cnt;
    logic        timeout_hit;
    logic [1:0]  status;
    logic [31:0] rdata_q;

    // Two flops for metastability, the third holds the previous level for edge detection.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            clk_sync <= 3'b111;
        end else begin
            clk_sync <= {clk_sync[1:0], nubus_clk_n};
        end
    end

    assign sample = clk_sync[1] & ~clk_sync[2];
    assign drive  = ~clk_sync[1] & clk_sync[2];

    always_comb begin
        addr_a    = ~ad_n_i;
        start_hit = sample && !start_n_i && ack_n_i &&
                    (addr_a[31:28] == 4'hF) && (addr_a[27:24] == ~id_n);
        be_calc   = 4'b1111;
        if (!tm0_n_i) begin
            be_calc = 4'b0001 << addr_a[1:0];
        end else if (addr_a[1:0] == 2'b01) begin
            be_calc = 4'b0011;
        end else if (addr_a[1:0] == 2'b11) begin
            be_calc = 4'b1100;
        end
    end

    assign timeout_hit      = (tmo_cnt >= TIMEOUT_CNT);
    assign busy             = (state != S_IDLE);
    assign state_dbg        = state;
    assign nubus_master_dir = 1'b0;

    // Local handshake: req_valid rises with all req_* fields stable and stays up,
    // fields unchanged, until the cycle where req_ready is also 1; that cycle is the
    // transfer. resp_valid is a one-cycle pulse answering the accepted request.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= S_IDLE;
            nubus_oe  <= 1'b1;
            tmoen     <= 1'b0;
            ad_oe     <= 1'b0;
            ack_n_o   <= 1'b1;
            tm0_n_o   <= 1'b1;
            tm1_n_o   <= 1'b1;
            ad_n_o    <= '1;
            req_valid <= 1'b0;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_be    <= '0;
            req_wdata <= '0;
            drop      <= 1'b0;
            tmo_cnt   <= '0;
            status    <= ST_OK_N;
            rdata_q   <= '0;
        end else begin
            nubus_oe <= 1'b0;

            if (sample && (state != S_IDLE) && (tmo_cnt != 8'hFF)) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end

            // A response owed to an abandoned request is swallowed here.
            if (drop && resp_valid) begin
                drop <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (start_hit) begin
                        req_addr <= addr_a[23:2];
                        req_we   <= ~tm1_n_i;
                        req_be   <= be_calc;
                        tmo_cnt  <= '0;
                        if (tm1_n_i) begin
                            req_valid <= ~drop;
                            state     <= S_REQ;
                        end else begin
                            state <= S_WDATA;
                        end
                    end
                end

                S_WDATA: begin
                    if (sample) begin
                        req_wdata <= addr_a;
                        req_valid <= ~drop;
                        state     <= S_REQ;
                    end
                end

                S_REQ: begin
                    if (req_valid && req_ready) begin
                        req_valid <= 1'b0;
                        if (timeout_hit) begin
                            drop    <= 1'b1;
                            status  <= ST_ERR_N;
                            rdata_q <= '0;
                            tmoen   <= 1'b1;
                            state   <= S_ASETUP;
                        end else begin
                            state <= S_WAIT;
                        end
                    end else if (timeout_hit) begin
                        req_valid <= 1'b0;
                        status    <= ST_ERR_N;
                        rdata_q   <= '0;
                        tmoen     <= 1'b1;
                        state     <= S_ASETUP;
                    end else if (!req_valid && !drop) begin
                        req_valid <= 1'b1;
                    end
                end

                S_WAIT: begin
                    if (resp_valid) begin
                        rdata_q <= req_we ? 32'h0 : resp_rdata;
                        status  <= ST_OK_N;
                        tmoen   <= 1'b1;
                        state   <= S_ASETUP;
                    end else if (timeout_hit) begin
                        drop    <= 1'b1;
                        status  <= ST_ERR_N;
                        rdata_q <= '0;
                        tmoen   <= 1'b1;
                        state   <= S_ASETUP;
                    end
                end

                S_ASETUP: begin
                    if (drive) begin
                        ack_n_o            <= 1'b0;
                        {tm1_n_o, tm0_n_o} <= status;
                        ad_oe              <= ~req_we;
                        ad_n_o             <= ~rdata_q;
                        state              <= S_ACK;
                    end
                end

                S_ACK: begin
                    if (drive) begin
                        ack_n_o <= 1'b1;
                        tm0_n_o <= 1'b1;
                        tm1_n_o <= 1'b1;
                        ad_oe   <= 1'b0;
                        ad_n_o  <= '1;
                        state   <= S_RELEASE;
                    end
                end

                S_RELEASE: begin
                    tmoen <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nubus_slave_ctrl.sv
// Randomised scoreboard bench for nubus_slave_ctrl: NuBus-side driver, local responder,
// request and ack monitors checked against a transaction-level model.
`timescale 1ns/1ps
module tb_nubus_slave_ctrl;
  localparam int unsigned TIMEOUT  = 4;
  localparam logic [1:0]  ST_OK_N  = 2'b00;
  localparam logic [1:0]  ST_ERR_N = 2'b01;
  localparam int          ACK_SPAN = 8;

  logic        sys_clk, sys_rst, nubus_clk_n;
  logic [3:0]  id_n;
  logic        start_n_i, ack_n_i, tm0_n_i, tm1_n_i;
  logic [31:0] ad_n_i;
  logic        ack_n_o, tm0_n_o, tm1_n_o;
  logic [31:0] ad_n_o;
  logic        ad_oe, nubus_oe, nubus_master_dir, tmoen;
  logic        req_valid, req_ready, req_we;
  logic [21:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        busy, drop;
  logic [2:0]  state_dbg;

  nubus_slave_ctrl #(.TIMEOUT(TIMEOUT), .ST_OK_N(ST_OK_N), .ST_ERR_N(ST_ERR_N)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .nubus_clk_n(nubus_clk_n), .id_n(id_n),
    .start_n_i(start_n_i), .ack_n_i(ack_n_i), .tm0_n_i(tm0_n_i), .tm1_n_i(tm1_n_i),
    .ad_n_i(ad_n_i), .ack_n_o(ack_n_o), .tm0_n_o(tm0_n_o), .tm1_n_o(tm1_n_o),
    .ad_n_o(ad_n_o), .ad_oe(ad_oe), .nubus_oe(nubus_oe), .nubus_master_dir(nubus_master_dir),
    .tmoen(tmoen), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .busy(busy), .drop(drop), .state_dbg(state_dbg)
  );

  int vectors;
  int miscompares;

  logic [58:0] req_exp_q[$];   // {we, addr[21:0], be[3:0], wdata[31:0]}
  logic [34:0] ack_exp_q[$];   // {is_read, tm1_n, tm0_n, ad_n[31:0]}
  logic [31:0] rsp_data_q[$];

  bit silent;
  int late_cnt, late_done;

  // ---------------- clocks ----------------
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    nubus_clk_n = 1'b1;
    #3;
    forever #40 nubus_clk_n = ~nubus_clk_n;
  end

  initial begin
    #2000000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_hit(input logic [31:0] a, input logic [3:0] id, input bit attn);
    int unsigned top  = a / 32'h1000_0000;
    int unsigned slot = (a / 32'h0100_0000) % 16;
    return !attn && (top == 15) && (slot == 15 - int'(id));
  endfunction

  function automatic logic [3:0] model_be(input logic [31:0] a, input bit byt);
    int unsigned lane = a % 4;
    if (byt) return 4'(1 << lane);
    if (lane == 1) return 4'b0011;
    if (lane == 3) return 4'b1100;
    return 4'b1111;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic nb_start(input logic [31:0] a, input bit we, input bit byt, input bit attn,
                          input logic [31:0] wdata, input logic [31:0] rd, input bit to,
                          output bit hit);
    logic [21:0] word;
    hit  = model_hit(a, id_n, attn);
    word = 22'((a % 32'h0100_0000) / 4);
    if (hit) begin
      req_exp_q.push_back({we, word, model_be(a, byt), (we ? wdata : 32'h0)});
      rsp_data_q.push_back(rd);
      if (to)
        ack_exp_q.push_back({!we, ST_ERR_N, 32'hFFFF_FFFF});
      else
        ack_exp_q.push_back({!we, ST_OK_N, (we ? 32'hFFFF_FFFF : ~rd)});
    end
    @(negedge nubus_clk_n);
    start_n_i = 1'b0;
    ack_n_i   = attn ? 1'b0 : 1'b1;
    ad_n_i    = ~a;
    tm1_n_i   = ~we;
    tm0_n_i   = ~byt;
    @(negedge nubus_clk_n);
    start_n_i = 1'b1;
    ack_n_i   = 1'b1;
    tm1_n_i   = 1'b1;
    tm0_n_i   = 1'b1;
    ad_n_i    = we ? ~wdata : $urandom;
    if (we) begin
      @(negedge nubus_clk_n);
      ad_n_i = $urandom;
    end
  endtask

  task automatic nb_finish(input bit hit);
    int n;
    bit bad;
    if (hit) begin
      n = 0;
      @(negedge sys_clk);
      while (busy && n < 400) begin
        @(negedge sys_clk);
        n++;
      end
      check("cycle_done_in_time", 64'(n >= 400), 64'd0);
      check("ack_scoreboard_drained", 64'(ack_exp_q.size()), 64'd0);
      check("req_scoreboard_drained", 64'(req_exp_q.size()), 64'd0);
    end else begin
      bad = 1'b0;
      repeat (24) begin
        @(negedge sys_clk);
        if (busy || tmoen || req_valid) bad = 1'b1;
      end
      check("miss_stays_idle", 64'(bad), 64'd0);
    end
  endtask

  // ---------------- local responder ----------------
  logic [31:0] pend_data;
  int          countdown;

  initial begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    countdown  = 0;
    late_done  = 0;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst && req_valid && req_ready) begin
        pend_data = (rsp_data_q.size() > 0) ? rsp_data_q.pop_front() : 32'h0;
        if (!silent) countdown = $urandom_range(1, 4);
      end
      if (sys_rst) countdown = 0;
      @(posedge sys_clk);
      #2;
      resp_valid = 1'b0;
      if (late_cnt != late_done) begin
        late_done++;
        resp_valid = 1'b1;
        resp_rdata = $urandom;
      end else if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          resp_valid = 1'b1;
          resp_rdata = pend_data;
        end
      end
      req_ready = silent ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- request monitor ----------------
  logic [58:0] rq;
  logic [58:0] held;
  bit          held_v;

  initial begin
    held_v = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (sys_rst) begin
        held_v = 1'b0;
      end else begin
        if (held_v)
          check("req_fields_stable", {4'h0, req_valid, req_we, req_addr, req_be, req_wdata},
                {4'h0, 1'b1, held});
        if (req_valid && req_ready) begin
          if (req_exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_req: addr %0h with no request expected", req_addr);
          end else begin
            rq = req_exp_q.pop_front();
            check("req_we", 64'(req_we), 64'(rq[58]));
            check("req_addr", 64'(req_addr), 64'(rq[57:36]));
            check("req_be", 64'(req_be), 64'(rq[35:32]));
            if (rq[58]) check("req_wdata", 64'(req_wdata), 64'(rq[31:0]));
          end
        end
        held_v = req_valid && !req_ready;
        held   = {req_we, req_addr, req_be, req_wdata};
      end
    end
  end

  // ---------------- ack monitor ----------------
  logic        prev_ack, prev_tmoen;
  bit          in_ack, chk_rel;
  int          width;
  logic [34:0] ae;

  initial begin
    prev_ack   = 1'b1;
    prev_tmoen = 1'b0;
    in_ack     = 1'b0;
    chk_rel    = 1'b0;
    width      = 0;
    forever begin
      @(negedge sys_clk);
      if (sys_rst) begin
        in_ack  = 1'b0;
        chk_rel = 1'b0;
      end else begin
        if (chk_rel) begin
          check("tmoen_falls_after_ack", 64'(tmoen), 64'd0);
          chk_rel = 1'b0;
        end
        if (!in_ack && prev_ack && !ack_n_o) begin
          in_ack = 1'b1;
          width  = 1;
          check("tmoen_leads_ack", 64'(prev_tmoen), 64'd1);
          if (ack_exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_ack: tm %b with no ack expected", {tm1_n_o, tm0_n_o});
          end else begin
            ae = ack_exp_q.pop_front();
            check("ack_status", 64'({tm1_n_o, tm0_n_o}), 64'(ae[33:32]));
            check("ack_ad_oe", 64'(ad_oe), 64'(ae[34]));
            if (ae[34]) check("ack_read_data", 64'(ad_n_o), 64'(ae[31:0]));
          end
        end else if (in_ack && !ack_n_o) begin
          width++;
        end else if (in_ack && ack_n_o) begin
          in_ack = 1'b0;
          check("ack_span", 64'(width), 64'(ACK_SPAN));
          check("ack_release_tm_ad", 64'({tm1_n_o, tm0_n_o, ad_oe}), 64'(3'b110));
          check("tmoen_held_at_release", 64'(tmoen), 64'd1);
          chk_rel = 1'b1;
        end
      end
      prev_ack   = ack_n_o;
      prev_tmoen = tmoen;
    end
  end

  // ---------------- main sequence ----------------
  bit          hit, bad;
  logic [31:0] ra, rw;
  bit          rwe, rbyt, rattn;
  int          kind, n;

  initial begin
    vectors     = 0;
    miscompares = 0;
    silent      = 1'b0;
    late_cnt    = 0;
    sys_rst     = 1'b1;
    start_n_i   = 1'b1;
    ack_n_i     = 1'b1;
    tm0_n_i     = 1'b1;
    tm1_n_i     = 1'b1;
    ad_n_i      = '1;
    id_n        = 4'b0001;

    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_nubus_oe", 64'(nubus_oe), 64'd1);
    check("rst_tmoen_ad_oe", 64'({tmoen, ad_oe}), 64'd0);
    check("rst_ack_tm", 64'({ack_n_o, tm1_n_o, tm0_n_o}), 64'(3'b111));
    check("rst_ad_n_o", 64'(ad_n_o), 64'hFFFF_FFFF);
    check("rst_req", 64'({req_valid, req_we, req_addr, req_be}), 64'd0);
    check("rst_req_wdata", 64'(req_wdata), 64'd0);
    check("rst_busy_drop_dir", 64'({busy, drop, nubus_master_dir}), 64'd0);

    @(posedge sys_clk);
    #2 sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);
    check("run_nubus_oe", 64'(nubus_oe), 64'd0);
    check("run_master_dir", 64'(nubus_master_dir), 64'd0);

    // Directed read hit, byte write and address miss in slot E.
    nb_start(32'hFE00_0104, 1'b0, 1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, hit);
    nb_finish(hit);
    nb_start(32'hFE00_0013, 1'b1, 1'b1, 1'b0, 32'h0000_00AA, 32'h0, 1'b0, hit);
    nb_finish(hit);
    nb_start(32'hFD00_0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, hit);
    nb_finish(hit);

    // Random mix of hits, misses and attention-style starts across slot IDs.
    for (int i = 0; i < 30; i++) begin
      id_n  = 4'($urandom_range(0, 15));
      kind  = $urandom_range(0, 9);
      ra    = $urandom;
      ra[31:24] = {4'hF, ~id_n};
      rattn = 1'b0;
      if (kind == 0) ra[31:28] = 4'($urandom_range(0, 14));
      else if (kind == 1) ra[27:24] = ~id_n ^ 4'($urandom_range(1, 15));
      else if (kind == 2) rattn = 1'b1;
      rwe  = $urandom_range(0, 1);
      rbyt = $urandom_range(0, 1);
      rw   = $urandom;
      nb_start(ra, rwe, rbyt, rattn, rw, $urandom, 1'b0, hit);
      nb_finish(hit);
    end

    // Timeout: request accepted but never answered.
    id_n   = 4'b0001;
    silent = 1'b1;
    nb_start(32'hFE00_00F0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h1234_5678, 1'b1, hit);
    nb_finish(hit);
    silent = 1'b0;
    check("drop_after_timeout", 64'(drop), 64'd1);

    // Next read is latched but held back until the late response is swallowed.
    nb_start(32'hFE00_0208, 1'b0, 1'b0, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0, hit);
    bad = 1'b0;
    repeat (10) begin
      @(negedge sys_clk);
      if (req_valid || !busy) bad = 1'b1;
    end
    check("req_held_while_drop", 64'(bad), 64'd0);
    late_cnt++;
    nb_finish(hit);
    check("drop_cleared", 64'(drop), 64'd0);

    // Reset during the ack period.
    nb_start(32'hFE00_0300, 1'b0, 1'b0, 1'b0, 32'h0, $urandom, 1'b0, hit);
    n = 0;
    while (ack_n_o && n < 400) begin
      @(negedge sys_clk);
      n++;
    end
    check("ack_reached_for_reset", 64'(n >= 400), 64'd0);
    @(posedge sys_clk);
    #2 sys_rst = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    check("midack_rst_ack", 64'({ack_n_o, tm1_n_o, tm0_n_o}), 64'(3'b111));
    check("midack_rst_tmoen_ad_oe", 64'({tmoen, ad_oe}), 64'd0);
    check("midack_rst_nubus_oe", 64'(nubus_oe), 64'd1);
    check("midack_rst_busy", 64'(busy), 64'd0);
    @(posedge sys_clk);
    #2 sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    nb_start(32'hFE00_0404, 1'b0, 1'b0, 1'b0, 32'h0, $urandom, 1'b0, hit);
    nb_finish(hit);
    nb_start(32'hFE00_0501, 1'b1, 1'b0, 1'b0, $urandom, 32'h0, 1'b0, hit);
    nb_finish(hit);

    repeat (20) @(negedge sys_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
